// File: rtl/multi_ch_sync_debounce.sv
// N-channel synchronizer + debounce + edge/sticky detect; an input change reaches sync_out on the SYNC_STAGES+DEBOUNCE_CNT-th edge.
// No backpressure: every output is a registered level or one-cycle pulse, valid every cycle.
module multi_ch_sync_debounce #(
    parameter int   NUM_CH       = 4,
    parameter int   SYNC_STAGES  = 2,
    parameter int   DEBOUNCE_CNT = 8,
    parameter logic RESET_VAL    = 1'b0,
    parameter int   STICKY_EDGE  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] async_in,
    input  logic [NUM_CH-1:0] sticky_clr,
    output logic [NUM_CH-1:0] sync_out,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    output logic [NUM_CH-1:0] sticky_flag,
    output logic              any_event
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [NUM_CH-1:0] RST_VEC  = {NUM_CH{RESET_VAL}};

    if (STICKY_EDGE < 0 || STICKY_EDGE > 2) begin : g_bad_sticky_edge
        $error("multi_ch_sync_debounce: STICKY_EDGE must be 0 (rise), 1 (fall) or 2 (both)");
    end
    if (SYNC_STAGES < 2 || NUM_CH < 1 || DEBOUNCE_CNT < 1) begin : g_bad_params
        $error("multi_ch_sync_debounce: need NUM_CH>=1, SYNC_STAGES>=2, DEBOUNCE_CNT>=1");
    end

    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
    logic [NUM_CH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_CH-1:0]                  level_q, level_d;
    logic [NUM_CH-1:0]                  rise_q, rise_d;
    logic [NUM_CH-1:0]                  fall_q, fall_d;
    logic [NUM_CH-1:0]                  flag_q, flag_d;
    logic [NUM_CH-1:0]                  flag_set;
    logic [NUM_CH-1:0]                  stable_s;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = async_in;
        for (int j = 1; j < SYNC_STAGES; j++) begin
            sync_d[j] = sync_q[j-1];
        end
    end

    assign stable_s = sync_q[SYNC_STAGES-1];

    // Any cycle where the synchronized input matches the accepted level restarts the run.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (stable_s[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_d[i] = stable_s[i];
                cnt_d[i]   = '0;
                rise_d[i]  = stable_s[i];
                fall_d[i]  = ~stable_s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        flag_set = rise_d | fall_d;
        if (STICKY_EDGE == 0) begin
            flag_set = rise_d;
        end else if (STICKY_EDGE == 1) begin
            flag_set = fall_d;
        end
        // Set has priority over a coincident clear.
        flag_d = flag_set | (flag_q & ~sticky_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {SYNC_STAGES{RST_VEC}};
            cnt_q   <= '0;
            level_q <= RST_VEC;
            rise_q  <= '0;
            fall_q  <= '0;
            flag_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            flag_q  <= flag_d;
        end
    end

    assign sync_out    = level_q;
    assign rise_pulse  = rise_q;
    assign fall_pulse  = fall_q;
    assign sticky_flag = flag_q;
    assign any_event   = |flag_q;

endmodule
